// File: rtl/vga_scan_ctrl.sv
// 640x480@60 raster timing generator with a 4:1 down-scaled framebuffer address
// output and a delay-matched colour/sync output stage.
`timescale 1ns/1ps

package vga_pkg;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vga_color_t;
endpackage

module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LAT      = 1
) (
    input  logic       i_vga_clk,
    input  logic       i_reset_n,
    input  vga_color_t i_color,
    output logic [7:0] o_pxlX,
    output logic [7:0] o_pxlY,
    output vga_color_t o_color,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active,
    output logic       o_vblank_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    sync_t      stage0;
    sync_t      dly [RD_LAT];
    sync_t      tail;

    // NOTE: every register below is updated with <= so all stages sample the
    // pre-edge values of their neighbours regardless of statement order.
    always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // NOTE: each output is assigned a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        stage0     = SYNC_IDLE;
        o_pxlX     = '0;
        o_pxlY     = '0;
        stage0.act = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        stage0.hs  = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        stage0.vs  = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        if (stage0.act) begin
            o_pxlX = 8'(h_cnt >> SCALE_SHIFT);
            o_pxlY = 8'(v_cnt >> SCALE_SHIFT);
        end
    end

    assign o_vblank_start = (h_cnt == '0) && (v_cnt == V_VIS);

    // NOTE: the delay line is reset on purpose; its contents reach the pins
    // directly, so a stale entry would glitch sync right after reset.
    always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dly[i] <= SYNC_IDLE;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                dly[i] <= dly[i-1];
            end
            dly[0] <= stage0;
        end
    end

    assign tail = dly[RD_LAT-1];

    // Colour from memory and the matching delayed sync land in one register.
    always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_color  <= '0;
            o_hsync  <= 1'b1;
            o_vsync  <= 1'b1;
            o_active <= 1'b0;
        end else begin
            o_color  <= tail.act ? i_color : '0;
            o_hsync  <= tail.hs;
            o_vsync  <= tail.vs;
            o_active <= tail.act;
        end
    end

endmodule
